alu_seq: RTL and testbench

Parametrised, handshaked successor to the 16-bit combinational ALU. Adds width generality, a registered flag register (Z/N/C/V) owned by the block, a flag restore port, and an optional multi-cycle shift-add multiplier. Sits in the execute stage between the register-file read and write-back. Results and flags are registered; there is no output back-pressure.

---
 rtl/alu_seq_if.sv | 25 ++
 rtl/alu_seq.sv | 185 ++++++++++++++++++
 tb/tb_alu_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Operation/flag bus between the execute-stage driver (master) and alu_seq (slave).
interface alu_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic [2:0]       operation;
  logic             flags_load;
  logic [3:0]       flags_in;
  logic [WIDTH-1:0] result;
  logic             out_valid;
  logic [3:0]       flags_out;

  modport master (
    output in_valid, operand1, operand2, operation, flags_load, flags_in,
    input  in_ready, result, out_valid, flags_out
  );

  modport slave (
    input  in_valid, operand1, operand2, operation, flags_load, flags_in,
    output in_ready, result, out_valid, flags_out
  );
endinterface

// File: rtl/alu_seq.sv
// Execute-stage ALU with registered result and Z/N/C/V flag register plus flag restore.
// ALU_SEQ_MUL_EN: opcode 111 becomes a WIDTH-cycle shift-add multiply (else single-cycle MOV B).
module alu_seq #(
  parameter int unsigned WIDTH = 16
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_INC = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 3;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             ready_c;
  logic             accept;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_diff;
  logic [WIDTH:0]   inc_sum;
  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_flags;
  logic             done;
  logic [WIDTH-1:0] done_res;
  logic [3:0]       done_flags;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic             out_valid_q;

  assign a      = bus.operand1;
  assign b      = bus.operand2;
  assign op     = bus.operation;
  assign accept = bus.in_valid && ready_c;

  // Single-cycle datapath; C and V hold unless the opcode defines them.
  always_comb begin
    add_sum   = {1'b0, a} + {1'b0, b};
    sub_diff  = {1'b0, a} - {1'b0, b};
    inc_sum   = {1'b0, a} + (WIDTH + 1)'(1);
    alu_res   = b;
    alu_flags = flags_q;
    case (op)
      OP_ADD: begin
        alu_res           = add_sum[WIDTH-1:0];
        alu_flags[FLAG_C] = add_sum[WIDTH];
        alu_flags[FLAG_V] = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res           = sub_diff[WIDTH-1:0];
        alu_flags[FLAG_C] = sub_diff[WIDTH];
        alu_flags[FLAG_V] = (a[WIDTH-1] != b[WIDTH-1]) && (sub_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOT: alu_res = ~a;
      OP_INC: begin
        alu_res           = inc_sum[WIDTH-1:0];
        alu_flags[FLAG_C] = inc_sum[WIDTH];
        alu_flags[FLAG_V] = !a[WIDTH-1] && inc_sum[WIDTH-1];
      end
      default: alu_res = b;
    endcase
    alu_flags[FLAG_Z] = (alu_res == '0);
    alu_flags[FLAG_N] = alu_res[WIDTH-1];
  end

`ifdef ALU_SEQ_MUL_EN
  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   mul_cnt;
  logic [2*WIDTH-1:0] mul_acc;
  logic [2*WIDTH-1:0] mul_a;
  logic [2*WIDTH-1:0] mul_sum;
  logic [WIDTH-1:0]   mul_b;
  logic               mul_start;
  logic               mul_step;
  logic               mul_last;
  logic [3:0]         mul_flags;

  assign mul_start = accept && (op == OP_MUL);
  assign mul_last  = mul_step && (mul_cnt == CNT_W'(WIDTH - 1));
  assign mul_sum   = mul_acc + (mul_b[0] ? mul_a : '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (mul_start) state_next = MUL_BUSY;
      MUL_BUSY: if (mul_last)  state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    ready_c  = 1'b0;
    mul_step = 1'b0;
    case (state)
      IDLE:     ready_c  = 1'b1;
      MUL_BUSY: mul_step = 1'b1;
      default:  ready_c  = 1'b0;
    endcase
  end

  // Shift-add multiplier: A shifts left, B shifts right, one partial product per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_cnt <= '0;
      mul_acc <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
    end else if (mul_start) begin
      mul_cnt <= '0;
      mul_acc <= '0;
      mul_a   <= {{WIDTH{1'b0}}, a};
      mul_b   <= b;
    end else if (mul_step) begin
      mul_cnt <= mul_cnt + CNT_W'(1);
      mul_acc <= mul_sum;
      mul_a   <= mul_a << 1;
      mul_b   <= mul_b >> 1;
    end
  end

  always_comb begin
    mul_flags         = flags_q;
    mul_flags[FLAG_Z] = (mul_sum[WIDTH-1:0] == '0);
    mul_flags[FLAG_N] = mul_sum[WIDTH-1];
    mul_flags[FLAG_C] = |mul_sum[2*WIDTH-1:WIDTH];
  end

  assign done       = (accept && !mul_start) || mul_last;
  assign done_res   = mul_last ? mul_sum[WIDTH-1:0] : alu_res;
  assign done_flags = mul_last ? mul_flags : alu_flags;
`else
  assign ready_c    = 1'b1;
  assign done       = accept;
  assign done_res   = alu_res;
  assign done_flags = alu_flags;
`endif

  // Result/flag registers; a flag restore overrides the completing operation's flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= done;
      if (done) result_q <= done_res;
      if (bus.flags_load) flags_q <= bus.flags_in;
      else if (done)      flags_q <= done_flags;
    end
  end

  assign bus.in_ready  = ready_c;
  assign bus.result    = result_q;
  assign bus.flags_out = flags_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (WIDTH = 16); MUL cases only when ALU_SEQ_MUL_EN is defined.
module tb_alu_seq;
  localparam int WIDTH = 16;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_INC = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  alu_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one operation at a negedge; returns at the negedge after the accepting edge.
  task automatic drive_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.in_valid  = 1'b1;
    bus.operation = op;
    bus.operand1  = a;
    bus.operand2  = b;
    @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.flags_load = 1'b0;
  endtask

  task automatic expect_op(input string tag, input logic [15:0] res, input logic [3:0] fl);
    check({tag, "_res"},   32'(bus.result),    32'(res));
    check({tag, "_flags"}, 32'(bus.flags_out), 32'(fl));
    check({tag, "_ov"},    32'(bus.out_valid), 32'd1);
  endtask

  task automatic do_reset();
    bus.in_valid   = 1'b0;
    bus.operation  = OP_ADD;
    bus.operand1   = '0;
    bus.operand2   = '0;
    bus.flags_load = 1'b0;
    bus.flags_in   = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

`ifdef ALU_SEQ_MUL_EN
  // MUL accepted at edge t; keeps an ADD on the bus while busy, which must be ignored.
  task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] res, input logic [3:0] fl);
    int   low_cnt;
    logic ov_seen;
    low_cnt = 0;
    ov_seen = 1'b0;
    drive_op(OP_MUL, a, b);
    bus.in_valid  = 1'b1;
    bus.operation = OP_ADD;
    bus.operand1  = 16'h0001;
    bus.operand2  = 16'h0001;
    for (int k = 1; k < WIDTH; k++) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b1) low_cnt++;
      if (bus.out_valid !== 1'b0) ov_seen = 1'b1;
    end
    bus.in_valid = 1'b0;
    check({tag, "_busy_cycles"}, 32'(low_cnt), 32'd15);
    check({tag, "_early_ov"},    32'(ov_seen), 32'd0);
    @(negedge clk);
    expect_op(tag, res, fl);
    check({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
  endtask
`endif

  initial begin
    logic ov_seen;
    do_reset();
    check("rst_res",   32'(bus.result),    32'h0);
    check("rst_flags", 32'(bus.flags_out), 32'h0);
    check("rst_ov",    32'(bus.out_valid), 32'd0);
    check("rst_ready", 32'(bus.in_ready),  32'd1);

    drive_op(OP_ADD, 16'hFFFF, 16'h0001); expect_op("add_carry", 16'h0000, 4'b0101);
    @(negedge clk);
    check("add_pulse", 32'(bus.out_valid), 32'd0);
    check("add_hold",  32'(bus.result),    32'h0);

    drive_op(OP_SUB, 16'h0FFE, 16'h0FFF); expect_op("sub_borrow", 16'hFFFF, 4'b0110);
    drive_op(OP_ADD, 16'h7FFF, 16'h0001); expect_op("add_ovf",    16'h8000, 4'b1010);
    drive_op(OP_AND, 16'h00F0, 16'h000F); expect_op("and_hold",   16'h0000, 4'b1001);
    drive_op(OP_OR,  16'h1200, 16'h0034); expect_op("or",         16'h1234, 4'b1000);
    drive_op(OP_XOR, 16'hFF00, 16'h0F0F); expect_op("xor",        16'hF00F, 4'b1010);
    drive_op(OP_NOT, 16'h00FF, 16'h1234); expect_op("not",        16'hFF00, 4'b1010);
    drive_op(OP_INC, 16'hFFFF, 16'h0000); expect_op("inc_wrap",   16'h0000, 4'b0101);
    drive_op(OP_INC, 16'h7FFF, 16'h0000); expect_op("inc_ovf",    16'h8000, 4'b1010);
    drive_op(OP_SUB, 16'h8000, 16'h0001); expect_op("sub_ovf",    16'h7FFF, 4'b1000);
    drive_op(OP_SUB, 16'h0005, 16'h0005); expect_op("sub_zero",   16'h0000, 4'b0001);

    // Back-to-back single-cycle ops
    drive_op(OP_ADD, 16'h0001, 16'h0002); expect_op("b2b0", 16'h0003, 4'b0000);
    drive_op(OP_ADD, 16'h8000, 16'h8000); expect_op("b2b1", 16'h0000, 4'b1101);
    check("b2b_ready", 32'(bus.in_ready), 32'd1);

    // Flag restore collides with a completing op
    bus.flags_load = 1'b1;
    bus.flags_in   = 4'b1000;
    drive_op(OP_ADD, 16'hFFFF, 16'h0001); expect_op("collide", 16'h0000, 4'b1000);

    // Flag restore alone
    bus.flags_load = 1'b1;
    bus.flags_in   = 4'b0110;
    @(negedge clk);
    bus.flags_load = 1'b0;
    check("fload_flags", 32'(bus.flags_out), 32'h6);
    check("fload_ov",    32'(bus.out_valid), 32'd0);
    check("fload_res",   32'(bus.result),    32'h0);

`ifdef ALU_SEQ_MUL_EN
    do_reset();
    run_mul("mul_big",   16'h0100, 16'h0100, 16'h0000, 4'b0101);
    run_mul("mul_small", 16'h0003, 16'h0005, 16'h000F, 4'b0000);
    drive_op(OP_ADD, 16'h0002, 16'h0003); expect_op("after_mul", 16'h0005, 4'b0000);
    run_mul("mul_ff",    16'hFFFF, 16'hFFFF, 16'h0001, 4'b0100);

    // Reset in the middle of a multiply
    drive_op(OP_MUL, 16'h0003, 16'h0005);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_res",   32'(bus.result),    32'h0);
    check("abort_flags", 32'(bus.flags_out), 32'h0);
    check("abort_ov",    32'(bus.out_valid), 32'd0);
    check("abort_ready", 32'(bus.in_ready),  32'd1);
    ov_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) ov_seen = 1'b1;
    end
    check("abort_no_ov", 32'(ov_seen), 32'd0);
`else
    // Opcode 111 is MOV B: Z/N update, C/V hold (flags currently 0110)
    drive_op(OP_MUL, 16'h1234, 16'h8001); expect_op("mov_neg",  16'h8001, 4'b0110);
    drive_op(OP_MUL, 16'h5555, 16'h0000); expect_op("mov_zero", 16'h0000, 4'b0101);
    check("mov_ready", 32'(bus.in_ready), 32'd1);
    ov_seen = 1'b0;
    @(negedge clk);
    if (bus.out_valid !== 1'b0) ov_seen = 1'b1;
    check("mov_pulse", 32'(ov_seen), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
